cpu_run_ctrl: RTL and testbench

Run controller that sequences the 16-bit accumulator CPU and shares its single-port RAM with a host. While idle it holds the CPU in reset and gives the RAM to the host for program load and readback. On command it hands the RAM to the CPU, releases reset and counts cycles. It stops the run on halt (self-jump), timeout or abort, then returns RAM ownership to the host.

---
 rtl/cpu_run_ctrl_pkg.sv | 24 ++
 rtl/cpu_run_ctrl_owner_mux.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and defaults for the CPU run controller.
// State encoding, RAM owner select and the saturating cycle-count helper live here.
package cpu_run_ctrl_pkg;

  localparam int DATA_W       = 16;
  localparam int HALT_CYC_DEF = 12;
  localparam int MAX_CYC_DEF  = 100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } run_state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CPU  = 1'b1
  } ram_owner_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_owner_mux.sv
// Combinational RAM port selection between the host path and the CPU.
// The owner select comes from the run controller FSM.
module ram_owner_mux
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned ADD_LEN = 13
) (
  input  ram_owner_e          owner,
  input  logic                host_wr,
  input  logic [ADD_LEN-1:0]  host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic                cpu_wr,
  input  logic [ADD_LEN-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                ram_wr,
  output logic [ADD_LEN-1:0]  ram_addr,
  output logic [DATA_W-1:0]   ram_wdata
);

  always_comb begin
    ram_wr    = host_wr;
    ram_addr  = host_addr;
    ram_wdata = host_wdata;
    if (owner == OWN_CPU) begin
      ram_wr    = cpu_wr;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the CPU in reset while the host owns the RAM, then
// runs it until halt (unchanged PC), cycle-limit timeout or abort.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned ADD_LEN  = 13,
  parameter int unsigned HALT_CYC = HALT_CYC_DEF,
  parameter int unsigned MAX_CYC  = MAX_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADD_LEN-1:0]  ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                rd_req,
  output logic                rd_ready,
  input  logic [ADD_LEN-1:0]  rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                halted,
  output logic                timed_out,
  output logic [ADD_LEN-1:0]  halt_pc,
  output logic [31:0]         cycle_count,
  output logic                cpu_rst,
  input  logic                cpu_wrEn,
  input  logic [ADD_LEN-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [ADD_LEN-1:0]  cpu_pc,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                ram_wrEn,
  output logic [ADD_LEN-1:0]  ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int HALT_W = $clog2(HALT_CYC + 1);

  run_state_e          state;
  ram_owner_e          owner;
  logic [ADD_LEN-1:0]  pc_q;
  logic [HALT_W-1:0]   halt_cnt;
  logic [HALT_W-1:0]   halt_nxt;
  logic [31:0]         cnt_nxt;
  logic                hit_halt;
  logic                hit_to;
  logic                idle;
  logic [ADD_LEN-1:0]  host_addr;

  assign idle     = (state == ST_IDLE);
  assign owner    = idle ? OWN_HOST : OWN_CPU;
  assign ld_ready = idle;
  assign rd_ready = idle && !ld_valid;

  // A load always wins the single RAM port; an idle port parks on address 0.
  assign host_addr = ld_valid ? ld_addr : (rd_req ? rd_addr : '0);

  assign rd_data   = ram_rdata;
  assign cpu_rdata = ram_rdata;

  assign halt_nxt = (cpu_pc == pc_q) ? halt_cnt + HALT_W'(1) : '0;
  assign cnt_nxt  = sat_inc32(cycle_count);
  assign hit_halt = (halt_nxt >= HALT_W'(HALT_CYC));
  assign hit_to   = (cnt_nxt >= 32'(MAX_CYC));

  ram_owner_mux #(.ADD_LEN(ADD_LEN)) u_mux (
    .owner      (owner),
    .host_wr    (ld_valid),
    .host_addr  (host_addr),
    .host_wdata (ld_data),
    .cpu_wr     (cpu_wrEn),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .ram_wr     (ram_wrEn),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cpu_rst     <= 1'b1;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
      halt_pc     <= '0;
      cycle_count <= '0;
      halt_cnt    <= '0;
      rd_valid    <= 1'b0;
      pc_q        <= '0;
    end else begin
      pc_q     <= cpu_pc;
      rd_valid <= idle && rd_req && !ld_valid;
      case (state)
        ST_IDLE: begin
          if (start && !ld_valid && !rd_req) begin
            state       <= ST_START;
            busy        <= 1'b1;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            halt_cnt    <= '0;
          end
        end
        ST_START: begin
          state   <= ST_RUN;
          cpu_rst <= 1'b0;
        end
        ST_RUN: begin
          cycle_count <= cnt_nxt;
          halt_cnt    <= halt_nxt;
          // Exit priority: abort, then halt, then timeout.
          if (abort || hit_halt || hit_to) begin
            state     <= ST_IDLE;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            halt_pc   <= cpu_pc;
            halted    <= !abort && hit_halt;
            timed_out <= !abort && !hit_halt && hit_to;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cpu_rst <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a behavioural RAM, a tiny CPU stub
// and a reference model of the run-exit rules.
module tb_cpu_run_ctrl;

  localparam int AW = 13;
  localparam int HC = 12;
  localparam int MC = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_valid = 1'b0, ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic rd_req = 1'b0, rd_ready, rd_valid;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic start = 1'b0, abort = 1'b0;
  logic busy, halted, timed_out, cpu_rst;
  logic [AW-1:0] halt_pc;
  logic [31:0] cycle_count;
  logic cpu_wrEn;
  logic [AW-1:0] cpu_addr, cpu_pc;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic ram_wrEn;
  logic [AW-1:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  int total = 0;
  int bad = 0;
  logic [15:0] ref_mem [int];

  always #5 clk = ~clk;

  cpu_run_ctrl #(.ADD_LEN(AW), .HALT_CYC(HC), .MAX_CYC(MC)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .start(start), .abort(abort), .busy(busy), .halted(halted), .timed_out(timed_out),
    .halt_pc(halt_pc), .cycle_count(cycle_count), .cpu_rst(cpu_rst),
    .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc),
    .cpu_rdata(cpu_rdata), .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM, one-cycle read latency
  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // CPU stub: 4-cycle instructions; 8xxx = jump, 4xxx = store 0x5A5A, else next
  logic [1:0] phase;
  logic [15:0] instr;
  logic [AW-1:0] pc;
  logic store_now;
  always @(posedge clk) begin
    if (cpu_rst) begin
      pc <= '0; phase <= 2'd0; instr <= 16'h0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd1) instr <= cpu_rdata;
      if (phase == 2'd3) pc <= instr[15] ? instr[AW-1:0] : pc + 1'b1;
    end
  end
  assign store_now = !cpu_rst && (phase == 2'd2) && (instr[15:14] == 2'b01);
  assign cpu_pc    = pc;
  assign cpu_wrEn  = store_now;
  assign cpu_addr  = store_now ? instr[AW-1:0] : pc;
  assign cpu_wdata = 16'h5A5A;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[int'(a)] = d;
    @(posedge clk);
    #1 ld_valid = 1'b0;
  endtask

  // Reference model: exit on abort, else PC unchanged for HC consecutive
  // cycles, else MC run cycles. reason: 1 abort, 2 halt, 3 timeout.
  task automatic run_model(input int abort_at, output int reason, output logic [AW-1:0] exit_pc);
    int k, r;
    logic [AW-1:0] prev, pcv;
    bit done;
    reason = 0; exit_pc = '0; k = 0; r = 0; done = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b exp=1", busy); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL start_cpu_rst got=%b exp=1", cpu_rst); end
    prev = cpu_pc;
    while (!done && k < 200) begin
      @(negedge clk); #1;
      k++;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy k=%0d got=%b exp=1", k, busy); end
      total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL run_cpu_rst k=%0d got=%b exp=0", k, cpu_rst); end
      total++; if ({ld_ready, rd_ready} !== 2'b00) begin bad++; $display("FAIL run_host_ready k=%0d got=%b exp=00", k, {ld_ready, rd_ready}); end
      total++; if ({ram_wrEn, ram_addr} !== {cpu_wrEn, cpu_addr}) begin
        bad++; $display("FAIL run_ram_mux k=%0d got=%b/%h exp=%b/%h", k, ram_wrEn, ram_addr, cpu_wrEn, cpu_addr);
      end
      if (cpu_wrEn) begin
        total++; if (ram_wdata !== cpu_wdata) begin bad++; $display("FAIL run_ram_wdata got=%h exp=%h", ram_wdata, cpu_wdata); end
      end
      if (k == 1) begin
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL run_first_addr got=%h exp=0", ram_addr); end
      end
      pcv = cpu_pc;
      r = (pcv == prev) ? r + 1 : 0;
      prev = pcv;
      if (k == abort_at) begin abort = 1'b1; reason = 1; end
      else if (r >= HC) reason = 2;
      else if (k >= MC) reason = 3;
      if (reason != 0) begin done = 1; exit_pc = pcv; end
    end
    if (!done) begin
      total++; bad++; $display("FAIL run_bound no exit predicted within 200 cycles");
    end
    @(negedge clk); abort = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL end_busy got=%b exp=0", busy); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL end_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL end_ld_ready got=%b exp=1", ld_ready); end
    total++; if (halted !== (reason == 2)) begin bad++; $display("FAIL end_halted got=%b exp=%b", halted, reason == 2); end
    total++; if (timed_out !== (reason == 3)) begin bad++; $display("FAIL end_timed_out got=%b exp=%b", timed_out, reason == 3); end
    total++; if (halt_pc !== exit_pc) begin bad++; $display("FAIL end_halt_pc got=%h exp=%h", halt_pc, exit_pc); end
    total++; if (cycle_count !== 32'(k)) begin bad++; $display("FAIL end_cycle_count got=%0d exp=%0d", cycle_count, k); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if ({busy, halted, timed_out, rd_valid} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, halted, timed_out, rd_valid});
    end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (halt_pc !== '0 || cycle_count !== 32'd0) begin
      bad++; $display("FAIL reset_status got=%h/%0d exp=0/0", halt_pc, cycle_count);
    end
    total++; if ({ram_wrEn, ram_addr} !== '0) begin bad++; $display("FAIL reset_ram_idle got=%b/%h exp=0/0", ram_wrEn, ram_addr); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    rst = 1'b0;
  endtask

  task automatic test_load_read();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = AW'(i); ld_data = 16'(i); ref_mem[i] = 16'(i);
      #1;
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready i=%0d got=%b exp=1", i, ld_ready); end
      total++; if ({ram_wrEn, ram_addr, ram_wdata} !== {1'b1, AW'(i), 16'(i)}) begin
        bad++; $display("FAIL load_ram i=%0d got=%b/%h/%h exp=1/%h/%h", i, ram_wrEn, ram_addr, ram_wdata, i, i);
      end
    end
    @(negedge clk);
    ld_valid = 1'b0; rd_req = 1'b1; rd_addr = AW'(2); #1;
    total++; if ({rd_ready, ram_wrEn, ram_addr} !== {2'b10, AW'(2)}) begin
      bad++; $display("FAIL read_accept got=%b/%b/%h exp=1/0/2", rd_ready, ram_wrEn, ram_addr);
    end
    @(negedge clk);
    rd_req = 1'b0; #1;
    total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0002) begin
      bad++; $display("FAIL read_data got=%b/%h exp=1/0002", rd_valid, rd_data);
    end
    @(negedge clk); #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_collision();
    logic [AW-1:0] aw;
    logic [15:0] dw;
    aw = AW'(13'h200 + $urandom_range(0, 255));
    dw = 16'($urandom);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = aw; ld_data = dw; rd_req = 1'b1; rd_addr = AW'(1);
    ref_mem[int'(aw)] = dw;
    #1;
    total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL coll_rd_ready got=%b exp=0", rd_ready); end
    total++; if ({ram_wrEn, ram_addr, ram_wdata} !== {1'b1, aw, dw}) begin
      bad++; $display("FAIL coll_write got=%b/%h/%h exp=1/%h/%h", ram_wrEn, ram_addr, ram_wdata, aw, dw);
    end
    @(negedge clk);
    ld_valid = 1'b0; #1;
    total++; if (rd_valid !== 1'b0 || rd_ready !== 1'b1 || ram_addr !== AW'(1)) begin
      bad++; $display("FAIL coll_retry got=%b/%b/%h exp=0/1/1", rd_valid, rd_ready, ram_addr);
    end
    @(negedge clk);
    rd_req = 1'b0; #1;
    total++; if (rd_valid !== 1'b1 || rd_data !== ref_mem[1]) begin
      bad++; $display("FAIL coll_read got=%b/%h exp=1/%h", rd_valid, rd_data, ref_mem[1]);
    end
  endtask

  task automatic test_random_rw();
    bit exp_v;
    logic [15:0] exp_d;
    int op;
    for (int i = 0; i < 8; i++) host_write(AW'(13'h400 + i), 16'($urandom));
    exp_v = 0; exp_d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      op = $urandom_range(0, 3);
      ld_valid = (op == 1 || op == 3);
      rd_req   = (op == 2 || op == 3);
      ld_addr  = AW'(13'h400 + $urandom_range(0, 7));
      ld_data  = 16'($urandom);
      rd_addr  = AW'(13'h400 + $urandom_range(0, 7));
      #1;
      total++; if (rd_valid !== exp_v || (exp_v && rd_data !== exp_d)) begin
        bad++; $display("FAIL rand_read i=%0d got=%b/%h exp=%b/%h", i, rd_valid, rd_data, exp_v, exp_d);
      end
      total++; if (rd_ready !== !ld_valid) begin bad++; $display("FAIL rand_rd_ready i=%0d got=%b exp=%b", i, rd_ready, !ld_valid); end
      exp_v = rd_req && !ld_valid;
      if (exp_v) exp_d = ref_mem[int'(rd_addr)];
      if (ld_valid) ref_mem[int'(ld_addr)] = ld_data;
    end
    @(negedge clk);
    ld_valid = 1'b0; rd_req = 1'b0; #1;
    total++; if (rd_valid !== exp_v || (exp_v && rd_data !== exp_d)) begin
      bad++; $display("FAIL rand_read_last got=%b/%h exp=%b/%h", rd_valid, rd_data, exp_v, exp_d);
    end
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = AW'(13'h300); ld_data = 16'h1234; start = 1'b1;
    ref_mem[13'h300] = 16'h1234;
    @(negedge clk);
    ld_valid = 1'b0; rd_req = 1'b1; rd_addr = AW'(13'h300); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_with_load got=%b exp=0", busy); end
    @(negedge clk);
    rd_req = 1'b0; start = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_with_read got=%b exp=0", busy); end
    total++; if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
      bad++; $display("FAIL start_read_data got=%b/%h exp=1/1234", rd_valid, rd_data);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; #1;
    total++; if (busy !== 1'b0 || ld_ready !== 1'b1) begin
      bad++; $display("FAIL abort_idle got=%b/%b exp=0/1", busy, ld_ready);
    end
  endtask

  task automatic load_halt_prog(input int j, input logic [AW-1:0] sa);
    host_write(sa, 16'h0000);
    host_write(AW'(0), 16'h4000 | 16'(sa));
    for (int a = 1; a < j; a++) host_write(AW'(a), 16'($urandom) & 16'h3FFF);
    host_write(AW'(j), 16'h8000 | 16'(j));
  endtask

  task automatic test_halt();
    int j, reason;
    logic [AW-1:0] sa, epc;
    for (int n = 0; n < 3; n++) begin
      j  = $urandom_range(1, 5);
      sa = AW'(13'h100 + $urandom_range(0, 255));
      load_halt_prog(j, sa);
      run_model(0, reason, epc);
      total++; if (halted !== 1'b1 || halt_pc !== AW'(j)) begin
        bad++; $display("FAIL halt_result n=%0d got=%b/%h exp=1/%h", n, halted, halt_pc, j);
      end
      @(negedge clk);
      rd_req = 1'b1; rd_addr = sa;
      @(negedge clk);
      rd_req = 1'b0; #1;
      total++; if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A) begin
        bad++; $display("FAIL halt_cpu_store n=%0d got=%b/%h exp=1/5a5a", n, rd_valid, rd_data);
      end
      ref_mem[int'(sa)] = 16'h5A5A;
    end
  endtask

  task automatic test_timeout();
    int reason;
    logic [AW-1:0] epc;
    for (int a = 0; a < 16; a++) host_write(AW'(a), 16'($urandom) & 16'h3FFF);
    run_model(0, reason, epc);
    total++; if ({timed_out, halted} !== 2'b10 || cycle_count !== 32'(MC)) begin
      bad++; $display("FAIL timeout_result got=%b/%b/%0d exp=1/0/%0d", timed_out, halted, cycle_count, MC);
    end
  endtask

  task automatic test_rst_run();
    int reason;
    logic [AW-1:0] epc;
    load_halt_prog(3, AW'(13'h1F0));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; #1;
    total++; if (busy !== 1'b1 || cpu_rst !== 1'b0) begin
      bad++; $display("FAIL start_in_run got=%b/%b exp=1/0", busy, cpu_rst);
    end
    rst = 1'b1; rd_req = 1'b1; rd_addr = AW'(2);
    @(negedge clk);
    rst = 1'b0; rd_req = 1'b0; #1;
    total++; if ({busy, halted, timed_out, rd_valid, cpu_rst} !== 5'b00001) begin
      bad++; $display("FAIL rst_run_flags got=%b exp=00001", {busy, halted, timed_out, rd_valid, cpu_rst});
    end
    total++; if (halt_pc !== '0 || cycle_count !== 32'd0) begin
      bad++; $display("FAIL rst_run_status got=%h/%0d exp=0/0", halt_pc, cycle_count);
    end
    run_model(0, reason, epc);
    total++; if (halted !== 1'b1 || halt_pc !== AW'(3)) begin
      bad++; $display("FAIL rst_rerun got=%b/%h exp=1/3", halted, halt_pc);
    end
    @(negedge clk);
    rst = 1'b1; rd_req = 1'b1; rd_addr = AW'(3);
    @(negedge clk);
    rst = 1'b0; rd_req = 1'b0; #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_drop_read got=%b exp=0", rd_valid); end
  endtask

  task automatic test_abort();
    int reason;
    logic [AW-1:0] epc;
    run_model(1, reason, epc);
    total++; if ({halted, timed_out, busy, cpu_rst, ld_ready} !== 5'b00011) begin
      bad++; $display("FAIL abort_result got=%b exp=00011", {halted, timed_out, busy, cpu_rst, ld_ready});
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_collision();
    test_random_rw();
    test_start_ignored();
    test_halt();
    test_timeout();
    test_rst_run();
    test_abort();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
